vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
Frame-level sequencer for the VGA display path. It drives a horizontal and a vertical axis counter, each walking SYNC → BACK_PORCH → ACTIVE → FRONT_PORCH. It produces hsync, vsync, display-enable, active-pixel coordinates and line/frame strobes for the pixel generator. It divides the system clock down to the pixel rate and starts and stops scanout only on frame boundaries.

Parameters:
CLK_DIV, 2, system clocks per pixel; must be ≥1; 1 means a tick every clk.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels; H_TOTAL = 800.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch in lines; V_TOTAL = 525.
SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level request to run scanout
running  output  1  high while in RUN or DRAIN
pix_tick  output  1  one-clk pulse every CLK_DIV clks; counters advance only on it
hsync  output  1  horizontal sync, level per SYNC_ACTIVE
vsync  output  1  vertical sync, level per SYNC_ACTIVE
de  output  1  display enable; both axes in ACTIVE
x  output  10  active pixel column, 0..H_ACTIVE-1; 0 when de=0
y  output  10  active line, 0..V_ACTIVE-1; 0 when not in V ACTIVE
line_start  output  1  one-clk pulse when h_cnt becomes 0
frame_start  output  1  one-clk pulse when h_cnt and v_cnt both become 0

Behaviour:
- Clock and reset: clk is the system clock; reset is asynchronous and active-high.
- Reset values: state IDLE; div counter 0; h_cnt and v_cnt 0; hsync and vsync = ~SYNC_ACTIVE; de, x, y, line_start, frame_start, running, pix_tick all 0.
- Divider:
  - div counter counts 0..CLK_DIV-1 and runs in every state.
  - pix_tick is high for the clk in which div = CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly high.
- h_cnt phases: SYNC 0..95, BP 96..143, ACTIVE 144..783, FP 784..799, then wraps to 0.
- v_cnt: increments when h_cnt wraps; phases SYNC 0..1, BP 2..34, ACTIVE 35..514, FP 515..524, then wraps to 0.
- Output timing:
  - All outputs are registered and decoded from next-state counter values, so they update on the same edge as h_cnt/v_cnt with zero added latency.
  - x = h_cnt - (H_SYNC+H_BP) while in H ACTIVE.
  - y = v_cnt - (V_SYNC+V_BP) while in V ACTIVE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0; syncs inactive; de 0. On pix_tick with enable=1 → RUN; that same edge raises frame_start and line_start with h=v=0.
  - RUN: counters advance on each pix_tick. If enable=0 is sampled → DRAIN, with counters unaffected.
  - DRAIN: continues scanning. At the tick where the frame would wrap (h=799, v=524) → IDLE with no frame_start. If enable returns to 1 before that tick → back to RUN, and the frame continues seamlessly.
- Partial frames: a frame already begun is always completed, and none is ever emitted partially.
- Pulse width: line_start and frame_start last exactly one clk, coincident with the pix_tick edge that zeroes the counter.
- Simultaneous events: a frame wrap in RUN with enable=0 in the same cycle goes to IDLE directly.
- Reset mid-operation: immediate return to reset values; no final sync is completed.
- Widths: counters are 10 bits; H_TOTAL and V_TOTAL must each be ≤1024 (elaboration assertion).

Decomposition:
- Package vga_timing_pkg:
  - typedef enum phase_e {PH_SYNC, PH_BP, PH_ACTIVE, PH_FP};
  - typedef enum ctrl_state_e {IDLE, RUN, DRAIN};
  - default 640x480@60 constants and derived H_TOTAL/V_TOTAL.
- Sub-module vga_axis_counter:
  - parameterised by SYNC/BP/ACTIVE/FP;
  - inputs advance and clear; outputs cnt, phase, wrap, and next-value decode;
  - instanced once per axis.

Test Plan:
- Reset held 5 clks, then released with enable=0 → all outputs at reset values; pix_tick toggles every 2nd clk; running=0.
- enable=1 → frame_start and line_start pulse together; hsync low for 192 clks then high; de rises at h_cnt=144 with x=0 once v in ACTIVE; x=639 at h_cnt=783; de falls at 784; next line_start 1600 clks after the first.
- Full frame → frame_start period is exactly 840000 clks; vsync low for 2 lines (3200 clks); y runs 0..479; 480 lines carry de.
- enable dropped at v=100 → running stays 1, frame finishes through v=524, then IDLE, no frame_start, syncs inactive; enable re-raised at v=300 → no stop, next frame_start on time.
- reset asserted at h=500, v=200 → outputs at reset values asynchronously within the same cycle; after release with enable=1, first frame_start on the first pix_tick.
- CLK_DIV=1 build → pix_tick constant 1; line period 800 clks; frame period 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scanout path.
// Both axis counters and the frame sequencer import this package.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACTIVE, PH_FP} phase_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_e;

  // Each axis is laid out SYNC, BP, ACTIVE, FP starting at count 0.
  function automatic phase_e phaseOf(input logic [CNT_W-1:0] cnt,
                                     input int sync, input int bp,
                                     input int active);
    int c;
    c = int'(cnt);
    if (c < sync)                    return PH_SYNC;
    else if (c < sync + bp)          return PH_BP;
    else if (c < sync + bp + active) return PH_ACTIVE;
    else                             return PH_FP;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis.sv
// One scan axis (horizontal or vertical): a wrapping counter that also
// exposes the decode of its next value so the parent can register outputs.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_advance,
  input  logic             i_clear,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_cntNext,
  output phase_e           o_phaseNext,
  output logic [CNT_W-1:0] o_posNext
);

  localparam int               TOTAL = SYNC + BP + ACTIVE + FP;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] OFFS  = CNT_W'(SYNC + BP);

  if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_badTotal
    $error("vga_axis_counter: axis total %0d does not fit the counter", TOTAL);
  end

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;

  // Clear wins over advance so the sequencer can park the axis at zero.
  always_comb begin
    w_cntNext = r_cnt;
    if (i_clear)
      w_cntNext = '0;
    else if (i_advance)
      w_cntNext = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else
      r_cnt <= w_cntNext;
  end

  assign o_wrap      = (r_cnt == LAST);
  assign o_cntNext   = w_cntNext;
  assign o_phaseNext = phaseOf(w_cntNext, SYNC, BP, ACTIVE);
  assign o_posNext   = (o_phaseNext == PH_ACTIVE) ? w_cntNext - OFFS : '0;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Frame-level VGA timing sequencer: pixel-rate divider, two axis counters and
// an IDLE/RUN/DRAIN controller that only starts or stops on frame boundaries.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = DEF_CLK_DIV,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter logic SYNC_ACTIVE = 1'b0
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  output logic             o_running,
  output logic             o_pixTick,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_lineStart,
  output logic             o_frameStart
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_badDiv
    $error("vga_timing_ctrl: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_divNext;
  logic             r_pixTick;

  ctrl_state_e      r_state;
  ctrl_state_e      w_stateNext;

  logic             w_hWrap, w_vWrap, w_frameWrap;
  logic             w_nextRun, w_hAdv, w_vAdv, w_clear;
  logic [CNT_W-1:0] w_hCntNext, w_vCntNext, w_hPosNext, w_vPosNext;
  phase_e           w_hPhNext, w_vPhNext;

  logic             w_deNext, w_vActNext, w_lineStartNext, w_frameStartNext;

  logic             r_running, r_hsync, r_vsync, r_de, r_lineStart, r_frameStart;
  logic [CNT_W-1:0] r_x, r_y;

  // The divider free-runs in every state; pix_tick is registered so it is
  // high for exactly the clk in which the divider sits at its last count.
  assign w_divNext = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_pixTick <= 1'b0;
    end else begin
      r_div     <= w_divNext;
      r_pixTick <= (w_divNext == DIV_LAST);
    end
  end

  assign w_frameWrap = w_hWrap & w_vWrap;

  // A frame already begun is always finished: stopping is only decided on
  // the tick that would wrap the frame, using the enable level at that tick.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:  if (r_pixTick && i_enable) w_stateNext = RUN;
      RUN:   if (r_pixTick && w_frameWrap && !i_enable) w_stateNext = IDLE;
             else if (!i_enable)                         w_stateNext = DRAIN;
      DRAIN: if (r_pixTick && w_frameWrap && !i_enable) w_stateNext = IDLE;
             else if (i_enable)                          w_stateNext = RUN;
      default:                                           w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  assign w_nextRun = (w_stateNext != IDLE);
  assign w_clear   = !w_nextRun;
  assign w_hAdv    = r_pixTick && (r_state != IDLE);
  assign w_vAdv    = w_hAdv && w_hWrap;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP)
  ) u_hAxis (
    .clk         (clk),
    .reset       (reset),
    .i_advance   (w_hAdv),
    .i_clear     (w_clear),
    .o_wrap      (w_hWrap),
    .o_cntNext   (w_hCntNext),
    .o_phaseNext (w_hPhNext),
    .o_posNext   (w_hPosNext)
  );

  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP)
  ) u_vAxis (
    .clk         (clk),
    .reset       (reset),
    .i_advance   (w_vAdv),
    .i_clear     (w_clear),
    .o_wrap      (w_vWrap),
    .o_cntNext   (w_vCntNext),
    .o_phaseNext (w_vPhNext),
    .o_posNext   (w_vPosNext)
  );

  // Strobes only fire on a tick edge, so a parked zero count never repeats them.
  assign w_vActNext       = w_nextRun && (w_vPhNext == PH_ACTIVE);
  assign w_deNext         = w_vActNext && (w_hPhNext == PH_ACTIVE);
  assign w_lineStartNext  = r_pixTick && w_nextRun && (w_hCntNext == '0);
  assign w_frameStartNext = w_lineStartNext && (w_vCntNext == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running    <= 1'b0;
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_de         <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_running    <= w_nextRun;
      r_hsync      <= (w_nextRun && w_hPhNext == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync      <= (w_nextRun && w_vPhNext == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_de         <= w_deNext;
      r_x          <= w_deNext ? w_hPosNext : '0;
      r_y          <= w_vActNext ? w_vPosNext : '0;
      r_lineStart  <= w_lineStartNext;
      r_frameStart <= w_frameStartNext;
    end
  end

  assign o_running    = r_running;
  assign o_pixTick    = r_pixTick;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_de         = r_de;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_lineStart  = r_lineStart;
  assign o_frameStart = r_frameStart;

endmodule
